// File: rtl/ri_pkg.sv
// ri_pkg: shared constants and types for the prefetching instruction register.
// Default geometry (8-bit word, 4-bit opcode, 2-entry queue), the NOP opcode
// reported while no instruction is live, and the opcode/operand word layout.
package ri_pkg;

  localparam int RI_WORD_W = 8;
  localparam int RI_OPC_W  = 4;
  localparam int RI_DEPTH  = 2;
  localparam int RI_OPR_W  = RI_WORD_W - RI_OPC_W;

  // Opcode presented to the sequencer whenever the current IR is not valid.
  localparam logic [RI_OPC_W-1:0] OPC_NOP = '0;

  // Instruction word layout: opcode in the upper bits, operand below.
  typedef struct packed {
    logic [RI_OPC_W-1:0] opc;
    logic [RI_OPR_W-1:0] opr;
  } instr_t;

endpackage

// File: rtl/ri_fifo.sv
// ri_fifo: DEPTH-entry circular buffer feeding the instruction register.
// The caller qualifies push and pop: pop is only issued when non-empty, and
// push only when not full or when a pop happens in the same cycle. The head
// word is visible combinationally on rdata.
module ri_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Storage write at the tail.
  // NOTE: the storage array has no reset; count/empty guard every read, so
  // clearing it would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ri_queue.sv
// ri_queue: instruction register fronted by a prefetch queue.
// Words from the W bus are queued (Li_barra), moved into the current IR
// (Nx_barra), or bypassed straight into the IR when the queue is empty and
// both strobes arrive together. The opcode goes to the sequencer (NOP when
// not valid); the operand is driven onto the bus while Ei_barra is low.
// Optional feature macro: RI_PARITY_EN adds W_par / par_err parity checking.
module ri_queue
  import ri_pkg::*;
#(
  parameter int WORD_W = RI_WORD_W,
  parameter int OPC_W  = RI_OPC_W,
  parameter int DEPTH  = RI_DEPTH,
  localparam int OPR_W = WORD_W - OPC_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [WORD_W-1:0] W,
`ifdef RI_PARITY_EN
  input  logic              W_par,
  output logic              par_err,
`endif
  input  logic              Li_barra,
  input  logic              Nx_barra,
  input  logic              Ei_barra,
  output logic [OPC_W-1:0]  opcode,
  output tri logic [OPR_W-1:0] operand_out,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf
);

`ifdef RI_PARITY_EN
  localparam int DW = WORD_W + 1;
`else
  localparam int DW = WORD_W;
`endif

  logic              push_req;
  logic              adv_req;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DW-1:0]     fifo_wdata;
  logic [DW-1:0]     fifo_rdata;
  logic [WORD_W-1:0] ir;

  assign push_req = ~Li_barra;
  assign adv_req  = ~Nx_barra;

  // Bypass only when nothing is queued; otherwise the head has priority and
  // the incoming word joins the tail (legal even when full, since a slot frees).
  assign bypass    = push_req & adv_req & empty;
  assign fifo_pop  = adv_req & ~empty;
  assign fifo_push = push_req & ~bypass & (~full | fifo_pop);

`ifdef RI_PARITY_EN
  assign fifo_wdata = {W_par, W};
`else
  assign fifo_wdata = W;
`endif

  ri_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (CLR),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Current IR: load from bypass or queue head; an empty advance only drops valid.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ir    <= '0;
      valid <= 1'b0;
    end else if (bypass) begin
      ir    <= W;
      valid <= 1'b1;
    end else if (fifo_pop) begin
      ir    <= fifo_rdata[WORD_W-1:0];
      valid <= 1'b1;
    end else if (adv_req) begin
      valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by CLR.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push_req & full & ~adv_req)  ovf <= 1'b1;
      if (adv_req & empty & ~push_req) udf <= 1'b1;
    end
  end

`ifdef RI_PARITY_EN
  // Sticky parity error: stored even parity is checked as the word enters the IR.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      par_err <= 1'b0;
    end else if ((bypass & (^{W_par, W})) | (fifo_pop & (^fifo_rdata))) begin
      par_err <= 1'b1;
    end
  end
`endif

  assign opcode      = valid ? ir[WORD_W-1 -: OPC_W] : OPC_W'(OPC_NOP);
  assign operand_out = ~Ei_barra ? ir[OPR_W-1:0] : {OPR_W{1'bz}};

endmodule
